// File: rtl/cc_soft_rst_seq.sv
// Soft-reset sequencer: drains core AXI traffic, holds the core in reset,
// then releases it with a freshly latched boot address.
module cc_soft_rst_seq #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned OUT_W         = 4,
  parameter logic [31:0] BOOT_DEFAULT  = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rst_req_i,
  input  logic [31:0] boot_addr_i,
  input  logic        aw_hs_i,
  input  logic        b_hs_i,
  input  logic        ar_hs_i,
  input  logic        rlast_hs_i,
  output logic        block_o,
  output logic        core_rst_no,
  output logic [31:0] boot_addr_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_IDLE,
    S_DRAIN
  } state_e;

  localparam logic [15:0] TMO_LAST  = 16'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e state_q, state_d;

  logic [OUT_W-1:0] wr_cnt, rd_cnt;
  logic [OUT_W-1:0] wr_nxt, rd_nxt;
  logic [15:0]      timer_q;
  logic [7:0]       hold_q;
  logic [31:0]      req_addr;
  logic             hold_entry;
  logic             to_set;
  logic             req_ok;

  function automatic logic [OUT_W-1:0] upd(
    input logic [OUT_W-1:0] c,
    input logic             inc,
    input logic             dec
  );
    logic [OUT_W-1:0] r;
    r = c;
    unique case (1'b1)
      (inc && !dec): r = (&c) ? c : c + 1'b1;
      (dec && !inc): r = (c == '0) ? c : c - 1'b1;
      default:       r = c;
    endcase
    return r;
  endfunction

  assign wr_nxt = upd(wr_cnt, aw_hs_i, b_hs_i);
  assign rd_nxt = upd(rd_cnt, ar_hs_i, rlast_hs_i);
  assign req_ok = (state_q == S_IDLE) && rst_req_i;

  always_comb begin
    state_d    = state_q;
    hold_entry = 1'b0;
    to_set     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rst_req_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // a drain that completes on the timeout cycle is not a timeout
        if (wr_nxt == '0 && rd_nxt == '0) begin
          state_d    = S_HOLD;
          hold_entry = 1'b1;
        end else if (timer_q == TMO_LAST) begin
          state_d    = S_HOLD;
          hold_entry = 1'b1;
          to_set     = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_HOLD;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      timer_q     <= '0;
      hold_q      <= '0;
      req_addr    <= BOOT_DEFAULT;
      boot_addr_o <= BOOT_DEFAULT;
      timeout_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hold_entry) begin
        wr_cnt      <= '0;
        rd_cnt      <= '0;
        hold_q      <= '0;
        boot_addr_o <= req_addr;
      end else if (state_q == S_HOLD) begin
        hold_q <= hold_q + 1'b1;
      end else begin
        wr_cnt <= wr_nxt;
        rd_cnt <= rd_nxt;
      end
      if (req_ok) begin
        req_addr  <= boot_addr_i;
        timeout_o <= 1'b0;
        timer_q   <= '0;
      end
      if (state_q == S_DRAIN) timer_q <= timer_q + 1'b1;
      if (to_set) timeout_o <= 1'b1;
    end
  end

  assign block_o     = (state_q == S_DRAIN) || (state_q == S_HOLD);
  assign core_rst_no = (state_q != S_HOLD);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_RELEASE);

endmodule

// File: doc/cc_soft_rst_seq.md
# cc_soft_rst_seq

Soft-reset sequencer for the core complex: it replaces the direct level-sensitive soft-reset path from the system-config register to the core. On a reset request it blocks new core AXI traffic, drains the core's outstanding AXI transactions (bounded by a timeout), holds the core in reset for a fixed number of cycles, then releases it with a freshly latched boot address. It sits between the syscfg APB register block and the core/CRG, observing the core's AXI master port handshakes.

## Interface
- `HOLD_CYCLES`, default 16: cycles `core_rst_no` is held low per reset; allowed range 2..255.
- `DRAIN_TIMEOUT`, default 1024: maximum cycles spent in DRAIN before a forced reset; allowed range 2..65535.
- `OUT_W`, default 4: width of each outstanding-transaction counter.
- `BOOT_DEFAULT`, default 32'h8000_0000: reset value of `boot_addr_o`.

Ports (name, direction, width, meaning):
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `rst_req_i` in 1: single-cycle soft-reset request pulse from syscfg.
- `boot_addr_i` in 32: requested boot address, sampled with `rst_req_i`.
- `aw_hs_i` in 1: core master AW valid&ready.
- `b_hs_i` in 1: core master B valid&ready.
- `ar_hs_i` in 1: core master AR valid&ready.
- `rlast_hs_i` in 1: core master R valid&ready&last.
- `block_o` out 1: gates AW/AR valid of the core master port.
- `core_rst_no` out 1: active-low core reset to the core.
- `boot_addr_o` out 32: boot address presented to the core.
- `busy_o` out 1: high whenever state is not IDLE.
- `timeout_o` out 1: sticky; last drain ended by timeout.
- `done_o` out 1: one-cycle pulse when the core is released.

## Operation
- States: HOLD, RELEASE, IDLE, DRAIN. The reset state is HOLD, so the core is released HOLD_CYCLES cycles after `rst_ni` deasserts.
- IDLE:
  - `rst_req_i` = 1 → latch `boot_addr_i` into `req_addr`, clear `timeout_o`, clear the drain timer, go to DRAIN.
- DRAIN:
  - `block_o` = 1.
  - Timer increments every cycle.
  - Go to HOLD when `wr_cnt` = 0 and `rd_cnt` = 0. The counters are evaluated after the current cycle's update.
  - Otherwise, when the timer equals DRAIN_TIMEOUT−1, go to HOLD and set `timeout_o`.
  - Drain-complete and timeout in the same cycle count as drain-complete; `timeout_o` stays 0.
- HOLD:
  - `block_o` = 1 and `core_rst_no` = 0.
  - On entry: `boot_addr_o` ← `req_addr`, both counters cleared, hold counter cleared.
  - The hold counter counts HOLD_CYCLES cycles, then the state goes to RELEASE.
- RELEASE:
  - One cycle: `core_rst_no` = 1, `block_o` = 0, `done_o` = 1.
  - Then go to IDLE.
- Outstanding counters:
  - `wr_cnt` +1 on `aw_hs_i`, −1 on `b_hs_i`; both in the same cycle leaves it unchanged.
  - `rd_cnt` behaves the same with `ar_hs_i` / `rlast_hs_i`.
  - Each counter saturates at 2^OUT_W−1 and does not decrement below 0.
  - Handshake inputs are ignored in HOLD.
  - Handshakes still complete in DRAIN: `block_o` gates only new AW/AR, so in-flight addresses already granted are counted.
- `rst_req_i` outside IDLE is ignored. It is not queued.

## Timing
- Reset values:
  - state = HOLD, `core_rst_no` = 0, `block_o` = 1, `busy_o` = 1.
  - `boot_addr_o` = BOOT_DEFAULT, `req_addr` = BOOT_DEFAULT.
  - `timeout_o` = 0, `done_o` = 0, all counters 0.
- All outputs are registered or decoded directly from registered state. There is no combinational path from input to output.
- Request accepted at cycle t:
  - `busy_o` and `block_o` high from t+1 (DRAIN).
  - If both counters are 0 at t+1, HOLD begins at t+2.
  - `core_rst_no` low for cycles t+2 .. t+1+HOLD_CYCLES.
  - `done_o` and `core_rst_no` high at t+2+HOLD_CYCLES.
  - IDLE (`busy_o` = 0) at t+3+HOLD_CYCLES.
- `boot_addr_o` changes only on HOLD entry, so it is stable whenever `core_rst_no` = 1.
- Worst-case request-to-release latency: 1 + DRAIN_TIMEOUT + HOLD_CYCLES cycles.
- Asserting `rst_ni` mid-sequence aborts immediately to the reset values. The latched request address is lost; `boot_addr_o` returns to BOOT_DEFAULT.

## Test plan
- Power-on: release `rst_ni` → `core_rst_no` = 0 for exactly 16 cycles, then `done_o` pulses once. `boot_addr_o` = 32'h8000_0000 throughout.
- Idle request: `rst_req_i` with `boot_addr_i` = 32'h0000_1000 and no traffic → `block_o` at t+1, `core_rst_no` low t+2..t+17, `done_o` at t+18, `boot_addr_o` = 32'h1000 from t+2, `timeout_o` = 0.
- Drain:
  - Stimulus: 2 AW and 1 AR handshakes before the request; B responses at request+5 and request+9, RLAST at request+7.
  - Required: HOLD entry exactly 1 cycle after the last B; `timeout_o` = 0.
- Timeout: DRAIN_TIMEOUT = 8, one AW handshake and no B ever → HOLD after 8 DRAIN cycles. `timeout_o` = 1 until the next accepted request; counters are 0 after HOLD entry.
- Simultaneous events and saturation:
  - AW+B in the same cycle → `wr_cnt` unchanged.
  - 20 AW handshakes with OUT_W = 4 → `wr_cnt` = 15.
  - B with `wr_cnt` = 0 → stays 0.
  - `rst_req_i` during DRAIN/HOLD → no second sequence.
- Reset mid-HOLD: assert `rst_ni` at hold cycle 5 → all outputs return to reset values asynchronously. After deassertion a full 16-cycle hold follows and `boot_addr_o` = BOOT_DEFAULT.
